// File: rtl/ext_pipe_unit.sv
// Registered immediate/operand extension unit with valid/ready flow control.
// A main register plus a skid register sustain one transfer per cycle under backpressure.
module ext_pipe_unit #(
   parameter int unsigned IN_DWIDTH  = 16,
   parameter int unsigned OUT_DWIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_DWIDTH-1:0]  in_data,
   input  logic [1:0]            in_mode,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_DWIDTH-1:0] out_data,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   localparam int unsigned ExtW  = OUT_DWIDTH - IN_DWIDTH;
   localparam int unsigned ByteW = OUT_DWIDTH - 8;

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e                 state_q, state_d;
   logic [OUT_DWIDTH-1:0]  m_data_q, m_data_d;
   logic [TAG_WIDTH-1:0]   m_tag_q, m_tag_d;
   logic [OUT_DWIDTH-1:0]  s_data_q, s_data_d;
   logic [TAG_WIDTH-1:0]   s_tag_q, s_tag_d;
   logic [OUT_DWIDTH-1:0]  ext_data;
   logic                   in_fire;
   logic                   out_fire;

   always_comb begin
      ext_data = '0;
      unique case (in_mode)
         2'd0: ext_data = {{ExtW{in_data[IN_DWIDTH-1]}}, in_data};
         2'd1: ext_data = {{ExtW{1'b0}}, in_data};
         2'd2: ext_data = {in_data, {ExtW{1'b0}}};
         2'd3: ext_data = {{ByteW{in_data[7]}}, in_data[7:0]};
         default: ext_data = '0;
      endcase
   end

   assign in_ready  = (state_q != StFull);
   assign out_valid = (state_q != StEmpty);
   assign out_data  = m_data_q;
   assign out_tag   = m_tag_q;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_comb begin
      state_d  = state_q;
      m_data_d = m_data_q;
      m_tag_d  = m_tag_q;
      s_data_d = s_data_q;
      s_tag_d  = s_tag_q;
      case (state_q)
         StEmpty: begin
            if (in_fire) begin
               m_data_d = ext_data;
               m_tag_d  = in_tag;
               state_d  = StOne;
            end
         end
         StOne: begin
            if (in_fire && out_fire) begin
               m_data_d = ext_data;
               m_tag_d  = in_tag;
            end else if (out_fire) begin
               state_d = StEmpty;
            end else if (in_fire) begin
               // M is stalled, so the new result parks in the skid register
               s_data_d = ext_data;
               s_tag_d  = in_tag;
               state_d  = StFull;
            end
         end
         StFull: begin
            if (out_fire) begin
               m_data_d = s_data_q;
               m_tag_d  = s_tag_q;
               state_d  = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StEmpty;
         m_data_q <= '0;
         m_tag_q  <= '0;
         s_data_q <= '0;
         s_tag_q  <= '0;
      end else begin
         state_q  <= state_d;
         m_data_q <= m_data_d;
         m_tag_q  <= m_tag_d;
         s_data_q <= s_data_d;
         s_tag_q  <= s_tag_d;
      end
   end

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Directed self-checking bench for ext_pipe_unit, default and 12->20 bit variants.
module tb_ext_pipe_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag, out_tag;
   logic [31:0] out_data;

   logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
   logic [11:0] p_in_data;
   logic [1:0]  p_in_mode;
   logic [4:0]  p_in_tag, p_out_tag;
   logic [19:0] p_out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ext_pipe_unit #(.IN_DWIDTH(16), .OUT_DWIDTH(32), .TAG_WIDTH(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );

   ext_pipe_unit #(.IN_DWIDTH(12), .OUT_DWIDTH(20), .TAG_WIDTH(5)) dut_p (
      .clk(clk), .rst(rst),
      .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
      .in_mode(p_in_mode), .in_tag(p_in_tag),
      .out_valid(p_out_valid), .out_ready(p_out_ready),
      .out_data(p_out_data), .out_tag(p_out_tag)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m,
                        input logic [4:0] t);
      in_valid = v;
      in_data  = d;
      in_mode  = m;
      in_tag   = t;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 16'h1234, 2'd1, 5'd9);
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      checks++;
      if (out_data !== 32'h0 || out_tag !== 5'd0) begin
         errors++; $display("FAIL reset_data got %h/%0d want 0/0", out_data, out_tag);
      end
      checks++;
      if (p_out_valid !== 1'b0 || p_in_ready !== 1'b1 || p_out_data !== 20'h0) begin
         errors++;
         $display("FAIL reset_variant got v=%b r=%b d=%h want 0 1 0",
                  p_out_valid, p_in_ready, p_out_data);
      end
   endtask

   task automatic test_modes();
      logic [15:0] vd [5];
      logic [1:0]  vm [5];
      logic [31:0] ve [5];
      vd = '{16'h8001, 16'h8001, 16'h8001, 16'h1280, 16'h127F};
      vm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
      ve = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFFFF80, 32'h0000007F};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, vd[i], vm[i], 5'(i + 3));
         step();
         drive(1'b0, 16'h0, 2'd0, 5'd0);
         checks++;
         if (out_valid !== 1'b1 || out_data !== ve[i] || out_tag !== 5'(i + 3)) begin
            errors++;
            $display("FAIL mode_%0d got v=%b d=%h t=%0d want v=1 d=%h t=%0d",
                     i, out_valid, out_data, out_tag, ve[i], i + 3);
         end
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mode_%0d_drain got v=%b want 0", i, out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'(16'h0010 + i), 2'd1, 5'(i));
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stream_in_ready_%0d got %b want 1", i, in_ready);
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'(32'h10 + i) || out_tag !== 5'(i)) begin
            errors++;
            $display("FAIL stream_out_%0d got v=%b d=%h t=%0d want v=1 d=%h t=%0d",
                     i, out_valid, out_data, out_tag, 32'h10 + i, i);
         end
      end
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL stream_end got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 16'h0001, 2'd1, 5'd1);
      step();
      checks++;
      if (in_ready !== 1'b1 || out_data !== 32'h1) begin
         errors++;
         $display("FAIL bp_after_a got r=%b d=%h want r=1 d=00000001", in_ready, out_data);
      end
      drive(1'b1, 16'h0002, 2'd1, 5'd2);
      step();
      checks++;
      if (in_ready !== 1'b0 || out_data !== 32'h1) begin
         errors++;
         $display("FAIL bp_after_b got r=%b d=%h want r=0 d=00000001", in_ready, out_data);
      end
      drive(1'b1, 16'h0003, 2'd1, 5'd3);
      step();
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1 || out_tag !== 5'd1) begin
         errors++;
         $display("FAIL bp_stall got r=%b v=%b d=%h t=%0d want r=0 v=1 d=00000001 t=1",
                  in_ready, out_valid, out_data, out_tag);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h2 || out_tag !== 5'd2) begin
         errors++;
         $display("FAIL bp_out_b got v=%b d=%h t=%0d want v=1 d=00000002 t=2",
                  out_valid, out_data, out_tag);
      end
      step();
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h3 || out_tag !== 5'd3) begin
         errors++;
         $display("FAIL bp_out_c got v=%b d=%h t=%0d want v=1 d=00000003 t=3",
                  out_valid, out_data, out_tag);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_end got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b1;
      drive(1'b1, 16'h7FFF, 2'd0, 5'd7);
      step();
      checks++;
      if (out_data !== 32'h00007FFF || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL simul_first got d=%h r=%b want d=00007fff r=1", out_data, in_ready);
      end
      drive(1'b1, 16'hFFFF, 2'd0, 5'd8);
      step();
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF || out_tag !== 5'd8
          || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL simul_second got v=%b d=%h t=%0d r=%b want v=1 d=ffffffff t=8 r=1",
                  out_valid, out_data, out_tag, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL simul_end got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_reset_full();
      out_ready = 1'b0;
      drive(1'b1, 16'h0055, 2'd1, 5'd5);
      step();
      drive(1'b1, 16'h0066, 2'd1, 5'd6);
      step();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL rstfull_full got r=%b want 0", in_ready);
      end
      rst = 1'b1;
      drive(1'b1, 16'h0077, 2'd1, 5'd7);
      step();
      rst = 1'b0;
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_tag !== 5'd0) begin
         errors++;
         $display("FAIL rstfull_after got v=%b r=%b d=%h t=%0d want 0 1 0 0",
                  out_valid, in_ready, out_data, out_tag);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rstfull_ghost_%0d got v=%b want 0", i, out_valid);
         end
      end
   endtask

   task automatic test_param_variant();
      logic [11:0] vd [3];
      logic [1:0]  vm [3];
      logic [19:0] ve [3];
      vd = '{12'h800, 12'h800, 12'h880};
      vm = '{2'd0, 2'd2, 2'd3};
      ve = '{20'hFF800, 20'h80000, 20'hFFF80};
      p_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         p_in_valid = 1'b1;
         p_in_data  = vd[i];
         p_in_mode  = vm[i];
         p_in_tag   = 5'(i + 20);
         step();
         p_in_valid = 1'b0;
         checks++;
         if (p_out_valid !== 1'b1 || p_out_data !== ve[i] || p_out_tag !== 5'(i + 20)) begin
            errors++;
            $display("FAIL variant_%0d got v=%b d=%h t=%0d want v=1 d=%h t=%0d",
                     i, p_out_valid, p_out_data, p_out_tag, ve[i], i + 20);
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      p_in_valid = 1'b0;
      p_in_data = '0;
      p_in_mode = '0;
      p_in_tag = '0;
      p_out_ready = 1'b0;
      test_reset();
      test_modes();
      test_back_to_back();
      test_backpressure();
      test_simultaneous();
      test_reset_full();
      test_param_variant();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
